sprite_unit: RTL

Single-sprite pixel source driving one lane of the GPU's sprite bus (`rden_out[i]`, `sprite_data[i*8+:8]`). It compares the VGA controller's current `pixel`/`line` against the sprite's bounding box, fetches the 8-bit colour index from an external synchronous bitmap ROM, and asserts its read-enable only for opaque pixels. The GPU's one-hot encoder and mux then pick the winning lane for palette lookup. Position and visibility updates arrive via a valid/ready handshake and commit only at frame start, so a frame never tears.

---
 rtl/sprite_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_unit.sv
// Single-sprite pixel source: bounding-box hit test, bitmap ROM fetch and opaque-pixel output.
// Optional horizontal mirroring is compiled in with `define SPRITE_MIRROR_EN.
module sprite_unit #(
  parameter int CORDW  = 16,
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int AW     = $clog2(WIDTH*HEIGHT),
  parameter logic signed [CORDW-1:0] INIT_X = '0,
  parameter logic signed [CORDW-1:0] INIT_Y = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enb,
  input  logic signed [CORDW-1:0] pixel,
  input  logic signed [CORDW-1:0] line,
  input  logic                    pixel_0_line_0,
  input  logic signed [CORDW-1:0] pos_x,
  input  logic signed [CORDW-1:0] pos_y,
  input  logic                    vis_in,
`ifdef SPRITE_MIRROR_EN
  input  logic                    mirror_in,
`endif
  input  logic                    pos_valid,
  output logic                    pos_ready,
  output logic [AW-1:0]           rom_addr,
  input  logic [7:0]              rom_q,
  output logic                    rden_out,
  output logic [7:0]              sprite_data
);

  // Handshake: an update transfers on a cycle with pos_valid & pos_ready; pos_ready stays low
  // while a shadow update waits for the next enabled frame-start cycle.
  typedef enum logic {IDLE, PEND} state_t;

  localparam logic signed [CORDW:0] W_S = (CORDW+1)'(WIDTH);
  localparam logic signed [CORDW:0] H_S = (CORDW+1)'(HEIGHT);

  state_t                  state_q, state_d;
  logic                    pos_ready_q, pos_ready_d;
  logic signed [CORDW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic signed [CORDW-1:0] nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
  logic                    cur_vis_q, cur_vis_d, nxt_vis_q, nxt_vis_d;
  logic                    mirror;
`ifdef SPRITE_MIRROR_EN
  logic                    cur_mir_q, cur_mir_d, nxt_mir_q, nxt_mir_d;
`endif

  logic [AW-1:0]           rom_addr_q, rom_addr_d;
  logic                    hit1_q, hit1_d, hit2_q, hit2_d;
  logic                    rden_q, rden_d;
  logic [7:0]              data_q, data_d;

  logic signed [CORDW:0]   dx, dy;
  logic [CORDW-1:0]        dx_u, dy_u, col;
  logic                    hit;

  // Update handshake and frame-start commit
  always_comb begin
    state_d     = state_q;
    pos_ready_d = pos_ready_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cur_vis_d   = cur_vis_q;
    nxt_x_d     = nxt_x_q;
    nxt_y_d     = nxt_y_q;
    nxt_vis_d   = nxt_vis_q;
`ifdef SPRITE_MIRROR_EN
    cur_mir_d   = cur_mir_q;
    nxt_mir_d   = nxt_mir_q;
`endif
    case (state_q)
      IDLE: begin
        if (pos_valid) begin
          nxt_x_d     = pos_x;
          nxt_y_d     = pos_y;
          nxt_vis_d   = vis_in;
`ifdef SPRITE_MIRROR_EN
          nxt_mir_d   = mirror_in;
`endif
          state_d     = PEND;
          pos_ready_d = 1'b0;
        end
      end
      PEND: begin
        if (enb && pixel_0_line_0) begin
          cur_x_d     = nxt_x_q;
          cur_y_d     = nxt_y_q;
          cur_vis_d   = nxt_vis_q;
`ifdef SPRITE_MIRROR_EN
          cur_mir_d   = nxt_mir_q;
`endif
          state_d     = IDLE;
          pos_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        pos_ready_d = 1'b1;
      end
    endcase
  end

`ifdef SPRITE_MIRROR_EN
  assign mirror = cur_mir_q;
`else
  assign mirror = 1'b0;
`endif

  // Stage 1: offsets carry one extra bit so off-screen positions never wrap into the box
  always_comb begin
    dx   = $signed({pixel[CORDW-1], pixel}) - $signed({cur_x_q[CORDW-1], cur_x_q});
    dy   = $signed({line[CORDW-1], line}) - $signed({cur_y_q[CORDW-1], cur_y_q});
    hit  = cur_vis_q && !dx[CORDW] && (dx < W_S) && !dy[CORDW] && (dy < H_S);
    dx_u = dx[CORDW-1:0];
    dy_u = dy[CORDW-1:0];
    col  = mirror ? (CORDW'(WIDTH - 1) - dx_u) : dx_u;
  end

  // Pipeline advances only on pixel-clock enables
  always_comb begin
    rom_addr_d = rom_addr_q;
    hit1_d     = hit1_q;
    hit2_d     = hit2_q;
    rden_d     = rden_q;
    data_d     = data_q;
    if (enb) begin
      hit1_d = hit;
      if (hit) rom_addr_d = AW'(32'(dy_u) * 32'(WIDTH) + 32'(col));
      hit2_d = hit1_q;
      // rom_q now holds the word for the address registered alongside hit1
      rden_d = hit2_q && (rom_q != 8'd0);
      data_d = rden_d ? rom_q : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_ready_q <= 1'b1;
      cur_x_q     <= INIT_X;
      cur_y_q     <= INIT_Y;
      cur_vis_q   <= 1'b1;
      nxt_x_q     <= INIT_X;
      nxt_y_q     <= INIT_Y;
      nxt_vis_q   <= 1'b1;
`ifdef SPRITE_MIRROR_EN
      cur_mir_q   <= 1'b0;
      nxt_mir_q   <= 1'b0;
`endif
      rom_addr_q  <= '0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      rden_q      <= 1'b0;
      data_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      pos_ready_q <= pos_ready_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cur_vis_q   <= cur_vis_d;
      nxt_x_q     <= nxt_x_d;
      nxt_y_q     <= nxt_y_d;
      nxt_vis_q   <= nxt_vis_d;
`ifdef SPRITE_MIRROR_EN
      cur_mir_q   <= cur_mir_d;
      nxt_mir_q   <= nxt_mir_d;
`endif
      rom_addr_q  <= rom_addr_d;
      hit1_q      <= hit1_d;
      hit2_q      <= hit2_d;
      rden_q      <= rden_d;
      data_q      <= data_d;
    end
  end

  assign pos_ready   = pos_ready_q;
  assign rom_addr    = rom_addr_q;
  assign rden_out    = rden_q;
  assign sprite_data = data_q;

endmodule
